// File: rtl/grant_burst_sequencer.sv
// Turns a registered arbiter grant into a multi-beat address burst on a valid/ready port,
// pulsing a per-requester done once the final beat has been accepted.
module grant_burst_sequencer #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [ADDR_W-1:0] cmd0_addr,
    input  logic [LEN_W-1:0]  cmd0_len,
    input  logic [ADDR_W-1:0] cmd1_addr,
    input  logic [LEN_W-1:0]  cmd1_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_src,
    output logic              out_last,
    output logic              done_0,
    output logic              done_1,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for a granted requester that still holds req
    // BURST | presenting beats, advancing on each accepted beat
    // DONE  | one-cycle done pulse to the burst owner
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [LEN_W-1:0]  lat_len, lat_len_nxt;
    logic [LEN_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic              valid_nxt, src_nxt, last_nxt;
    logic              done_0_nxt, done_1_nxt, busy_nxt;
    logic              start_0, start_1;

    // A sticky grant alone is not enough; the requester must still be asking.
    assign start_0 = gnt_0 & req_0;
    assign start_1 = gnt_1 & req_1;
    assign cnt_inc = beat_cnt + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            lat_len   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_src   <= 1'b0;
            out_last  <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            lat_len   <= lat_len_nxt;
            out_valid <= valid_nxt;
            out_addr  <= addr_nxt;
            out_src   <= src_nxt;
            out_last  <= last_nxt;
            done_0    <= done_0_nxt;
            done_1    <= done_1_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        lat_len_nxt  = lat_len;
        valid_nxt    = out_valid;
        addr_nxt     = out_addr;
        src_nxt      = out_src;
        last_nxt     = out_last;
        done_0_nxt   = 1'b0;
        done_1_nxt   = 1'b0;
        busy_nxt     = busy;

        case (state)
            IDLE: begin
                if (start_0 || start_1) begin
                    state_nxt    = BURST;
                    valid_nxt    = 1'b1;
                    busy_nxt     = 1'b1;
                    beat_cnt_nxt = '0;
                    // Requester 0 wins if the arbiter ever grants both.
                    if (start_0) begin
                        src_nxt     = 1'b0;
                        addr_nxt    = cmd0_addr;
                        lat_len_nxt = cmd0_len;
                        last_nxt    = (cmd0_len == '0);
                    end else begin
                        src_nxt     = 1'b1;
                        addr_nxt    = cmd1_addr;
                        lat_len_nxt = cmd1_len;
                        last_nxt    = (cmd1_len == '0);
                    end
                end
            end
            BURST: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_nxt  = DONE;
                        valid_nxt  = 1'b0;
                        last_nxt   = 1'b0;
                        done_0_nxt = ~out_src;
                        done_1_nxt = out_src;
                    end else begin
                        addr_nxt     = out_addr + 1'b1;
                        beat_cnt_nxt = cnt_inc;
                        last_nxt     = (cnt_inc == lat_len);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_grant_burst_sequencer.sv
// Bench for grant_burst_sequencer: table-driven bursts, hand-written corner sequences and
// randomized bursts checked against an arithmetic address/beat model.
module tb_grant_burst_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_0, req_1, gnt_0, gnt_1;
    logic [15:0] cmd0_addr, cmd1_addr;
    logic [3:0]  cmd0_len, cmd1_len;
    logic        out_valid, out_ready, out_src, out_last;
    logic [15:0] out_addr;
    logic        done_0, done_1, busy;

    int total = 0;
    int bad   = 0;

    grant_burst_sequencer #(.ADDR_W(16), .LEN_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_0     (req_0),
        .req_1     (req_1),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .cmd0_addr (cmd0_addr),
        .cmd0_len  (cmd0_len),
        .cmd1_addr (cmd1_addr),
        .cmd1_len  (cmd1_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_src   (out_src),
        .out_last  (out_last),
        .done_0    (done_0),
        .done_1    (done_1),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          src;
        logic [15:0] addr;
        logic [3:0]  len;
        int          mode;      // 0: ready always, 1: fixed pattern, 2: random ready
        bit          both;
        logic [15:0] exp_last;
        int          exp_beats;
    } vec_t;

    vec_t vecs[6];
    bit   pat[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done0"}, done_0, 1'b0);
        chk({tag, "_done1"}, done_1, 1'b0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
    task automatic run_burst(input bit src, input logic [15:0] addr, input logic [3:0] len,
                             input int mode, input bit both,
                             output logic [15:0] last_addr, output int beats);
        int          i;
        int          cyc;
        bit          rdy;
        logic [15:0] exp_addr;
        beats     = 0;
        last_addr = 'x;
        chk("pre_busy", busy, 1'b0);
        if (src == 1'b0) begin
            cmd0_addr = addr;  cmd0_len = len;
            cmd1_addr = 16'($urandom); cmd1_len = 4'($urandom);
        end else begin
            cmd1_addr = addr;  cmd1_len = len;
            cmd0_addr = 16'($urandom); cmd0_len = 4'($urandom);
        end
        req_0 = (src == 1'b0) || both;
        gnt_0 = (src == 1'b0) || both;
        req_1 = (src == 1'b1) || both;
        gnt_1 = (src == 1'b1) || both;
        out_ready = 1'b0;
        @(negedge clock);
        chk("first_valid", out_valid, 1'b1);
        i   = 0;
        cyc = 0;
        while (i <= int'(len) && cyc < 400) begin
            exp_addr = addr + 16'(i);
            chk("beat_valid", out_valid, 1'b1);
            chk("beat_addr", out_addr, exp_addr);
            chk("beat_src", out_src, src);
            chk("beat_last", out_last, (i == int'(len)));
            chk("beat_busy", busy, 1'b1);
            chk("beat_nodone", done_0 | done_1, 1'b0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc < 7) ? pat[cyc] : 1'b1;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            if (rdy) begin
                last_addr = out_addr;
                beats++;
            end
            // Latched command must survive changes on every input while the burst runs.
            cmd0_addr = 16'($urandom); cmd0_len = 4'($urandom);
            cmd1_addr = 16'($urandom); cmd1_len = 4'($urandom);
            @(negedge clock);
            if (rdy) i++;
            cyc++;
        end
        if (cyc >= 400) chk("burst_timeout", 32'(i), 32'(len) + 1);
        chk("done_valid", out_valid, 1'b0);
        chk("done_last", out_last, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("done_own", src ? done_1 : done_0, 1'b1);
        chk("done_other", src ? done_0 : done_1, 1'b0);
        req_0 = 1'b0;
        req_1 = 1'b0;
        out_ready = $urandom_range(0, 1);
        @(negedge clock);
        chk_quiet("after_done");
    endtask

    initial begin
        logic [15:0] la;
        int          nb;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[0] = '{1'b0, 16'h0010, 4'd3,  0, 1'b0, 16'h0013, 4};
        vecs[1] = '{1'b0, 16'h0010, 4'd3,  1, 1'b0, 16'h0013, 4};
        vecs[2] = '{1'b1, 16'hFFFE, 4'd2,  0, 1'b0, 16'h0000, 3};
        vecs[3] = '{1'b0, 16'h1234, 4'd0,  0, 1'b0, 16'h1234, 1};
        vecs[4] = '{1'b1, 16'h0FF0, 4'd15, 2, 1'b0, 16'h0FFF, 16};
        vecs[5] = '{1'b0, 16'h0500, 4'd5,  0, 1'b1, 16'h0505, 6};

        reset = 1'b1;
        req_0 = 0; req_1 = 0; gnt_0 = 0; gnt_1 = 0;
        cmd0_addr = '0; cmd0_len = '0; cmd1_addr = '0; cmd1_len = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk_quiet("reset");
        chk("reset_addr", out_addr, 16'h0);
        chk("reset_last", out_last, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[k]) begin
            run_burst(vecs[k].src, vecs[k].addr, vecs[k].len, vecs[k].mode, vecs[k].both, la, nb);
            chk($sformatf("vec%0d_last_addr", k), la, vecs[k].exp_last);
            chk($sformatf("vec%0d_beats", k), 32'(nb), 32'(vecs[k].exp_beats));
        end

        // Sticky gnt_0 with req_0 low must not start a burst.
        run_burst(1'b0, 16'h0040, 4'd2, 0, 1'b0, la, nb);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("sticky_gnt0", gnt_0, 1'b1);
            chk_quiet("sticky");
            @(negedge clock);
        end
        run_burst(1'b1, 16'h0200, 4'd1, 0, 1'b0, la, nb);
        chk("sticky_then_1_beats", 32'(nb), 32'd2);

        // Async reset at beat 2 of an 8-beat burst.
        cmd0_addr = 16'h0100; cmd0_len = 4'd7;
        req_0 = 1'b1; gnt_0 = 1'b1; gnt_1 = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("pre_abort_addr", out_addr, 16'h0102);
        chk("pre_abort_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_quiet("abort");
        chk("abort_addr", out_addr, 16'h0);
        chk("abort_last", out_last, 1'b0);
        chk("abort_src", out_src, 1'b0);
        req_0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk_quiet("post_abort");
        end
        run_burst(1'b0, 16'h0300, 4'd1, 0, 1'b0, la, nb);
        chk("post_abort_beats", 32'(nb), 32'd2);

        for (int r = 0; r < 40; r++) begin
            bit          rs;
            bit          rb;
            logic [15:0] ra;
            logic [3:0]  rl;
            rb = ($urandom_range(0, 7) == 0);
            rs = rb ? 1'b0 : 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rl = 4'($urandom_range(0, 15));
            run_burst(rs, ra, rl, 2, rb, la, nb);
            chk("rand_beats", 32'(nb), 32'(rl) + 1);
            chk("rand_last_addr", la, ra + 16'(rl));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/grant_burst_sequencer.md
Name: grant_burst_sequencer

Overview:
- Sits directly downstream of the two-requester priority arbiter and consumes its registered grant lines (gnt_0, gnt_1).
- Converts a grant into a multi-beat address burst on a shared valid/ready port, on behalf of the granted requester.
- Latches that requester's start address and length, and pulses a per-requester done when the burst completes.
- Requesters hold req high until they see done, then drop it.

Parameters:
ADDR_W, 16, width of burst start address and output address
LEN_W, 4, width of length field; burst beats = len+1 (1..2^LEN_W)

Ports:
clock  input  1  clock
reset  input  1  reset, asynchronous, active-high
req_0  input  1  requester 0 request (same wire the arbiter sees)
req_1  input  1  requester 1 request
gnt_0  input  1  arbiter grant 0 (registered, sticky)
gnt_1  input  1  arbiter grant 1
cmd0_addr  input  ADDR_W  requester 0 burst start address
cmd0_len  input  LEN_W  requester 0 beats minus one
cmd1_addr  input  ADDR_W  requester 1 burst start address
cmd1_len  input  LEN_W  requester 1 beats minus one
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts beat
out_addr  output  ADDR_W  beat address
out_src  output  1  requester owning current burst (0/1)
out_last  output  1  final beat of burst
done_0  output  1  one-cycle pulse, requester 0 burst complete
done_1  output  1  one-cycle pulse, requester 1 burst complete
busy  output  1  high in BURST and DONE

Behaviour:
- Reset (async, any state): state=IDLE; out_valid, out_addr, out_src, out_last, done_0, done_1, busy all 0; beat counter 0; latched command cleared. No done pulse is emitted for an aborted burst.
- All outputs are registered.
- State machine states: IDLE, BURST, DONE.
- IDLE:
  - Start condition is evaluated at each edge: (gnt_0 & req_0) selects src=0; else (gnt_1 & req_1) selects src=1.
  - If both qualify (illegal arbiter state), src=0 wins.
  - A sticky grant with its req low does NOT start a burst.
  - On start: latch addr and len of the selected requester; next cycle out_valid=1, out_addr=latched addr, out_src=src, busy=1, out_last=(len==0).
  - Latency: start sampled at edge t -> first beat valid in the cycle after edge t.
- BURST:
  - out_valid stays 1; out_addr, out_src, out_last are held stable while out_ready=0.
  - A beat is accepted at an edge with out_valid & out_ready.
  - On accept of a non-last beat: out_addr+1 (modulo 2^ADDR_W, wrapping 2^ADDR_W-1 -> 0), beat counter +1, out_last=(counter+1==len).
  - Full throughput: one beat per cycle while out_ready=1.
  - On accept of the last beat: -> DONE; out_valid=0, out_last=0.
  - cmd*/req*/gnt* changes during BURST are ignored; the command latched at start is used.
- DONE:
  - Exactly one cycle: done_<src>=1, busy=1. Then -> IDLE with done=0 and busy=0.
  - The requester drops req on the edge ending DONE, so the stale sticky grant seen in IDLE is not re-served.
- Back-to-back:
  - Earliest re-start is sampled on the first IDLE edge. Minimum idle gap between bursts is 1 cycle (the IDLE cycle).
- len=2^LEN_W-1 gives 2^LEN_W beats; the counter must not overflow before out_last.
- out_ready is ignored when out_valid=0.

Test Plan:
- req_0=1, arbiter grants gnt_0, cmd0_addr=0x0010, cmd0_len=3, out_ready=1 -> out_addr 0x10,0x11,0x12,0x13 on 4 consecutive cycles, out_last only on 0x13, out_src=0, then done_0 pulse 1 cycle, busy falls after DONE.
- Same burst with out_ready toggled 1,0,0,1,1,0,1 -> each address held stable while out_ready=0, exactly 4 accepts, addresses in order, single done_0.
- cmd1_addr=0xFFFE, cmd1_len=2, gnt_1&req_1 -> addresses 0xFFFE, 0xFFFF, 0x0000, out_src=1, done_1 pulse, done_0 stays 0.
- After done_0, req_0 drops but gnt_0 stays 1 (sticky) with req_1=0 -> no new burst, busy stays 0. Then req_1=1 -> arbiter moves to gnt_1 -> requester-1 burst starts the cycle after gnt_1 & req_1 is sampled.
- cmd0_len=0 -> single beat with out_valid=1 and out_last=1 in the same cycle, then done_0. Assert reset mid-burst at beat 2 of len=7 -> all outputs 0 immediately, no done pulse, IDLE after release.
- Force gnt_0=gnt_1=1 with both req high -> src=0 selected; cmd0 changed mid-burst -> burst uses the command latched at start.
